// File: rtl/pipe_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_rd_arbiter
//  Purpose  : Two-master (IFU / LSU) read arbiter in front of a single
//             AXI-lite-style read port (AR + R channels).
//             - One outstanding read at most.
//             - Grant decision is registered: a request seen in IDLE is
//               granted on the next clock, and only then reaches the memory.
//             - Ties are broken round-robin against the last granted master.
//             - A granted master may withdraw its request (e.g. fetch flush)
//               until the address handshake completes. After that the read
//               always runs to completion.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           clock, rising edge
//    rst_i           asynchronous, active-high reset
//    ifu_*           IFU read master (AR in, R out)
//    lsu_*           LSU read master (AR in, R out)
//    mem_*           memory read slave side (AR out, R in)
// ============================================================================
module pipe_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    // IFU master
    input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
    input  logic                  ifu_arvalid_i,
    output logic                  ifu_arready_o,
    output logic                  ifu_rvalid_o,
    output logic [DATA_WIDTH-1:0] ifu_rdata_o,
    input  logic                  ifu_rready_i,

    // LSU master
    input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
    input  logic                  lsu_arvalid_i,
    output logic                  lsu_arready_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    input  logic                  lsu_rready_i,

    // Memory slave
    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_rready_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_IFU = 2'd1,
        ST_GNT_LSU = 2'd2
    } state_t;

    // Identity of the last granted master.
    localparam logic c_LAST_IFU = 1'b0;
    localparam logic c_LAST_LSU = 1'b1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_ar_done;
    logic   w_ar_done_nxt;
    logic   r_last_gnt;
    logic   w_last_gnt_nxt;

    // ------------------------------------------------------------------------
    // Signals of the currently granted master, selected once so that the
    // next-state and output logic do not have to repeat the IFU/LSU split.
    // ------------------------------------------------------------------------
    logic                  w_gnt_any;
    logic                  w_gnt_lsu;
    logic                  w_sel_arvalid;
    logic                  w_sel_rready;
    logic [ADDR_WIDTH-1:0] w_sel_araddr;

    assign w_gnt_lsu     = (r_state == ST_GNT_LSU);
    assign w_gnt_any     = (r_state == ST_GNT_IFU) || (r_state == ST_GNT_LSU);
    assign w_sel_arvalid = w_gnt_lsu ? lsu_arvalid_i : ifu_arvalid_i;
    assign w_sel_rready  = w_gnt_lsu ? lsu_rready_i  : ifu_rready_i;
    assign w_sel_araddr  = w_gnt_lsu ? lsu_araddr_i  : ifu_araddr_i;

    // Handshake qualifiers. The R handshake is only meaningful once the
    // address phase is done, so a stray mem_rvalid_i before that point is
    // neither accepted nor forwarded.
    logic w_ar_hs;
    logic w_r_hs;

    assign w_ar_hs = w_gnt_any && !r_ar_done && w_sel_arvalid && mem_arready_i;
    assign w_r_hs  = w_gnt_any &&  r_ar_done && w_sel_rready  && mem_rvalid_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ar_done  <= 1'b0;
            r_last_gnt <= c_LAST_IFU;   // so that the first tie goes to LSU
        end else begin
            r_state    <= w_state_nxt;
            r_ar_done  <= w_ar_done_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_ar_done_nxt  = r_ar_done;
        w_last_gnt_nxt = r_last_gnt;

        case (r_state)
            ST_IDLE: begin
                w_ar_done_nxt = 1'b0;
                if (lsu_arvalid_i && ifu_arvalid_i) begin
                    // Tie: grant the master that was not served last.
                    if (r_last_gnt == c_LAST_IFU) begin
                        w_state_nxt    = ST_GNT_LSU;
                        w_last_gnt_nxt = c_LAST_LSU;
                    end else begin
                        w_state_nxt    = ST_GNT_IFU;
                        w_last_gnt_nxt = c_LAST_IFU;
                    end
                end else if (lsu_arvalid_i) begin
                    w_state_nxt    = ST_GNT_LSU;
                    w_last_gnt_nxt = c_LAST_LSU;
                end else if (ifu_arvalid_i) begin
                    w_state_nxt    = ST_GNT_IFU;
                    w_last_gnt_nxt = c_LAST_IFU;
                end
            end

            ST_GNT_IFU,
            ST_GNT_LSU: begin
                if (!r_ar_done) begin
                    // Request withdrawn before the address was taken:
                    // nothing was issued, so simply release the grant.
                    if (!w_sel_arvalid) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_ar_hs) begin
                        w_ar_done_nxt = 1'b1;
                    end
                end else if (w_r_hs) begin
                    w_state_nxt   = ST_IDLE;
                    w_ar_done_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_ar_done_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic. Everything defaults to zero, so IDLE and the non-granted
    // master never see anything but zeros.
    // ------------------------------------------------------------------------
    always_comb begin
        ifu_arready_o = 1'b0;
        ifu_rvalid_o  = 1'b0;
        ifu_rdata_o   = '0;
        lsu_arready_o = 1'b0;
        lsu_rvalid_o  = 1'b0;
        lsu_rdata_o   = '0;
        mem_araddr_o  = '0;
        mem_arvalid_o = 1'b0;
        mem_rready_o  = 1'b0;

        if (w_gnt_any) begin
            if (!r_ar_done) begin
                // Address phase: the address is passed straight through,
                // not captured, so the master must hold it until accepted.
                mem_araddr_o  = w_sel_araddr;
                mem_arvalid_o = w_sel_arvalid;
                if (w_gnt_lsu) begin
                    lsu_arready_o = mem_arready_i;
                end else begin
                    ifu_arready_o = mem_arready_i;
                end
            end else begin
                // Data phase.
                mem_rready_o = w_sel_rready;
                if (w_gnt_lsu) begin
                    lsu_rvalid_o = mem_rvalid_i;
                    lsu_rdata_o  = mem_rdata_i;
                end else begin
                    ifu_rvalid_o = mem_rvalid_i;
                    ifu_rdata_o  = mem_rdata_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_rd_arbiter.md
PIPE_RD_ARBITER -- requirements
Module: pipe_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all AR channels.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all R channels.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 ifu_araddr_i  input  ADDR_WIDTH  IFU fetch address.
REQ-006 ifu_arvalid_i  input  1  IFU read-address request.
REQ-007 ifu_arready_o  output  1  IFU read-address accepted.
REQ-008 ifu_rvalid_o  output  1  IFU read data valid.
REQ-009 ifu_rdata_o  output  DATA_WIDTH  IFU read data (instruction).
REQ-010 ifu_rready_i  input  1  IFU ready for read data.
REQ-011 lsu_araddr_i  input  ADDR_WIDTH  LSU load address.
REQ-012 lsu_arvalid_i  input  1  LSU read-address request.
REQ-013 lsu_arready_o  output  1  LSU read-address accepted.
REQ-014 lsu_rvalid_o  output  1  LSU read data valid.
REQ-015 lsu_rdata_o  output  DATA_WIDTH  LSU read data.
REQ-016 lsu_rready_i  input  1  LSU ready for read data.
REQ-017 mem_araddr_o  output  ADDR_WIDTH  memory read address.
REQ-018 mem_arvalid_o  output  1  memory read-address valid.
REQ-019 mem_arready_i  input  1  memory read-address accepted.
REQ-020 mem_rvalid_i  input  1  memory read data valid.
REQ-021 mem_rdata_i  input  DATA_WIDTH  memory read data.
REQ-022 mem_rready_o  output  1  arbiter ready for memory read data.

Function
REQ-023 Block SHALL implement states IDLE, GNT_IFU, GNT_LSU plus a registered ar_done flag and a registered last_gnt flag (IFU/LSU).
REQ-024 In IDLE all outputs SHALL be 0; grant decision is registered, i.e. one-cycle arbitration latency from arvalid to mem_arvalid_o.
REQ-025 IDLE transitions: only LSU requesting -> GNT_LSU; only IFU -> GNT_IFU; both -> master not equal to last_gnt; neither -> stay IDLE.
REQ-026 On entering a GNT state last_gnt SHALL be updated to that master.
REQ-027 GNT_x with ar_done=0: mem_araddr_o=x_araddr_i, mem_arvalid_o=x_arvalid_i, x_arready_o=mem_arready_i; mem_rready_o=0.
REQ-028 AR handshake (mem_arvalid_o & mem_arready_i) SHALL set ar_done next cycle; address is not registered by the arbiter.
REQ-029 GNT_x with ar_done=1: mem_arvalid_o=0, x_arready_o=0, x_rvalid_o=mem_rvalid_i, x_rdata_o=mem_rdata_i, mem_rready_o=x_rready_i.
REQ-030 R handshake (mem_rvalid_i & mem_rready_o) SHALL return to IDLE and clear ar_done next cycle; one outstanding read maximum.
REQ-031 If granted master drops arvalid while ar_done=0 (e.g. IFU flush), block SHALL return to IDLE next cycle without issuing a read.
REQ-032 After AR handshake the read SHALL complete to the granted master regardless of its arvalid; no abort.
REQ-033 Non-granted master SHALL see arready_o=0, rvalid_o=0, rdata_o=0 at all times.
REQ-034 mem_rvalid_i while ar_done=0 SHALL be ignored (mem_rready_o=0, not forwarded).
REQ-035 AR and R handshakes in the same cycle cannot occur (ar_done gates R); block SHALL not depend on that being excluded by memory.

Reset
REQ-036 On rst_i: state=IDLE, ar_done=0, last_gnt=IFU (LSU wins first tie); all outputs 0 while rst_i high.
REQ-037 Reset asserted mid-transaction SHALL abandon it; after release block starts in IDLE.

Verification
REQ-038 IFU-only: ifu_arvalid=1 addr 0x80000000, mem_arready=1, mem_rdata=0x00000413 after 2 cycles -> mem_arvalid one cycle after request, ifu_rvalid with 0x00000413, back to IDLE.
REQ-039 Tie after reset: both request (IFU 0x80000004, LSU 0x80001000) -> LSU served first, then IFU; mem_araddr sequence 0x80001000, 0x80000004.
REQ-040 Round-robin: both continuously requesting -> grants alternate LSU, IFU, LSU, IFU.
REQ-041 Flush: IFU granted, mem_arready=0, ifu_arvalid drops -> IDLE next cycle, no mem_arvalid afterwards, ifu_rvalid never 1.
REQ-042 Backpressure: LSU read, mem_rvalid=1, lsu_rready=0 for 3 cycles -> state holds GNT_LSU, mem_rready=0, IFU arready=0 throughout.
REQ-043 Reset mid-read: rst_i pulsed after AR handshake -> all outputs 0, state IDLE, next tie grants LSU.
